// File: rtl/gcode_command_queue.sv
// Circular command buffer that hands decoded G-code commands to control_unit one at a time
// over a start/finish/error handshake, with pause/resume/flush control and error status.
module gcode_command_queue #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDR_W        = 4,
    parameter bit          STOP_ON_ERROR = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [31:0]         wr_type,
    input  logic signed [31:0]  wr_x,
    input  logic signed [31:0]  wr_y,
    input  logic signed [31:0]  wr_z,
    input  logic signed [31:0]  wr_e0,
    input  logic signed [31:0]  wr_e1,
    input  logic                pause,
    input  logic                resume,
    input  logic                flush,
    output logic                start,
    output logic [31:0]         command_type,
    output logic signed [31:0]  command_x,
    output logic signed [31:0]  command_y,
    output logic signed [31:0]  command_z,
    output logic signed [31:0]  command_e0,
    output logic signed [31:0]  command_e1,
    input  logic                finish,
    input  logic                error,
    output logic [ADDR_W:0]     count,
    output logic                busy,
    output logic                halted,
    output logic [15:0]         err_count,
    output logic [31:0]         last_err_type
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef struct packed {
        logic [31:0] ctype;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] e0;
        logic [31:0] e1;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    entry_t              mem [DEPTH];
    entry_t              head;
    entry_t              entry_in;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                wr_en;
    logic                load;
    logic                done;
    logic                pop;
    logic                in_flight;
    logic                err_seen;

    assign wr_ready  = (count < CNT_W'(DEPTH)) && !flush;
    assign wr_en     = wr_valid && wr_ready;
    assign head      = mem[rd_ptr];
    assign entry_in  = {wr_type, wr_x, wr_y, wr_z, wr_e0, wr_e1};
    assign in_flight = (state == ISSUE) || (state == RELEASE);

    // Next-state and handshake strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done      = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && !pause && !flush) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (finish) begin
                    done      = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                // control_unit may hold finish through its own wait period
                if (!finish) begin
                    pop       = 1'b1;
                    state_nxt = (err_seen && STOP_ON_ERROR) ? HALT : IDLE;
                end
            end
            HALT: begin
                if (resume || flush) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    // Pointers and fill level; a flush in flight keeps only the head entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            if (in_flight) begin
                wr_ptr <= rd_ptr + ADDR_W'(1);
                if (pop) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                    count  <= '0;
                end else begin
                    count  <= CNT_W'(1);
                end
            end else begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered handshake, command and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start         <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b0;
            err_seen      <= 1'b0;
            err_count     <= '0;
            last_err_type <= '0;
            command_type  <= '0;
            command_x     <= '0;
            command_y     <= '0;
            command_z     <= '0;
            command_e0    <= '0;
            command_e1    <= '0;
        end else begin
            start  <= (state_nxt == ISSUE);
            busy   <= (state_nxt != IDLE);
            halted <= (state_nxt == HALT);
            if (load) begin
                command_type <= head.ctype;
                command_x    <= head.x;
                command_y    <= head.y;
                command_z    <= head.z;
                command_e0   <= head.e0;
                command_e1   <= head.e1;
            end
            if (done) begin
                err_seen <= error;
                if (error) begin
                    last_err_type <= command_type;
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gcode_command_queue.sv
// Bench for gcode_command_queue: the bench plays host and control_unit, and a queue-level
// model of the command stream is compared with the DUT outputs on every falling clock edge.
`timescale 1ns/1ps
module tb_gcode_command_queue;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    typedef struct packed {
        logic [31:0] t;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] e0;
        logic [31:0] e1;
    } ent_t;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_REL   = 2;
    localparam int P_HALT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_type, wr_x, wr_y, wr_z, wr_e0, wr_e1;
    logic        pause, resume, flush;
    logic        start;
    logic [31:0] command_type, command_x, command_y, command_z, command_e0, command_e1;
    logic        finish, error;
    logic [ADDR_W:0] count;
    logic        busy, halted;
    logic [15:0] err_count;
    logic [31:0] last_err_type;

    gcode_command_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STOP_ON_ERROR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_type(wr_type), .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z), .wr_e0(wr_e0), .wr_e1(wr_e1),
        .pause(pause), .resume(resume), .flush(flush),
        .start(start), .command_type(command_type),
        .command_x(command_x), .command_y(command_y), .command_z(command_z),
        .command_e0(command_e0), .command_e1(command_e1),
        .finish(finish), .error(error),
        .count(count), .busy(busy), .halted(halted),
        .err_count(err_count), .last_err_type(last_err_type)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending commands (head included while in flight) plus handshake phase
    ent_t        m_q[$];
    int          m_ph = P_IDLE;
    ent_t        m_cmd = '0;
    logic        m_errp = 1'b0;
    logic [15:0] m_ec = '0;
    logic [31:0] m_last = '0;

    task automatic model_step();
        bit   wr_ok, popnow, inflight;
        ent_t w;
        if (reset) begin
            m_q.delete();
            m_ph = P_IDLE; m_cmd = '0; m_errp = 1'b0; m_ec = '0; m_last = '0;
            return;
        end
        wr_ok    = wr_valid && (m_q.size() < int'(DEPTH)) && !flush;
        w        = {wr_type, wr_x, wr_y, wr_z, wr_e0, wr_e1};
        inflight = (m_ph == P_ISSUE) || (m_ph == P_REL);
        popnow   = 1'b0;
        case (m_ph)
            P_IDLE:  if (m_q.size() > 0 && !pause && !flush) begin m_cmd = m_q[0]; m_ph = P_ISSUE; end
            P_ISSUE: if (finish) begin
                         m_errp = error;
                         if (error) begin
                             if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
                             m_last = m_cmd.t;
                         end
                         m_ph = P_REL;
                     end
            P_REL:   if (!finish) begin popnow = 1'b1; m_ph = m_errp ? P_HALT : P_IDLE; end
            default: if (resume || flush) m_ph = P_IDLE;
        endcase
        if (flush) begin
            if (inflight && !popnow) begin
                while (m_q.size() > 1) void'(m_q.pop_back());
            end else begin
                m_q.delete();
            end
        end else begin
            if (popnow) void'(m_q.pop_front());
            if (wr_ok) m_q.push_back(w);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // Per-cycle comparison plus minimum low time between start pulses
    initial begin
        bit prev_start = 1'b0;
        bit seen = 1'b0;
        int low_run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_start = 1'b0; seen = 1'b0; low_run = 0;
            end else begin
                check("start",  32'(start),  32'(m_ph == P_ISSUE));
                check("busy",   32'(busy),   32'(m_ph != P_IDLE));
                check("halted", 32'(halted), 32'(m_ph == P_HALT));
                check("count",  32'(count),  32'(m_q.size()));
                check("wr_ready", 32'(wr_ready), 32'((m_q.size() < int'(DEPTH)) && !flush));
                check("err_count", 32'(err_count), 32'(m_ec));
                check("last_err_type", last_err_type, m_last);
                check("command_type", command_type, m_cmd.t);
                check("command_x",  command_x,  m_cmd.x);
                check("command_y",  command_y,  m_cmd.y);
                check("command_z",  command_z,  m_cmd.z);
                check("command_e0", command_e0, m_cmd.e0);
                check("command_e1", command_e1, m_cmd.e1);
                if (start && !prev_start && seen) check("start_gap_ge2", 32'(low_run >= 2), 32'd1);
                if (start) begin seen = 1'b1; low_run = 0; end
                else low_run++;
                prev_start = start;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] t, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] z, input logic [31:0] e0, input logic [31:0] e1);
        wr_valid = 1'b1;
        wr_type = t; wr_x = x; wr_y = y; wr_z = z; wr_e0 = e0; wr_e1 = e1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_start();
        int i = 0;
        while (!start && i < 200) begin tick(); i++; end
        check("wait_start", 32'(start), 32'd1);
    endtask

    task automatic serve(input int hold, input logic err);
        wait_start();
        if (start) begin
            finish = 1'b1; error = err;
            tick();
            error = 1'b0;
            repeat (hold) tick();
            finish = 1'b0;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_valid = 1'b0;
        wr_type = '0; wr_x = '0; wr_y = '0; wr_z = '0; wr_e0 = '0; wr_e1 = '0;
        pause = 1'b0; resume = 1'b0; flush = 1'b0; finish = 1'b0; error = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_start", 32'(start), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_cmd_type", command_type, 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);

        // Single command: start rises one cycle after the write
        wr(32'd1, 32'd100, -32'sd50, 32'd0, 32'd0, 32'd0);
        check("t1_start_low", 32'(start), 32'd0);
        tick();
        check("t1_start", 32'(start), 32'd1);
        check("t1_x", command_x, 32'd100);
        check("t1_y", command_y, 32'hFFFF_FFCE);
        finish = 1'b1; tick();
        check("t1_start_drop", 32'(start), 32'd0);
        finish = 1'b0; tick();
        check("t1_count", 32'(count), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);

        // Back-to-back with a long finish hold on the last command
        wr(32'd90, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        wr(32'd1, 32'd10, 32'd20, 32'd30, 32'd40, 32'd50);
        wr(32'd17, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1);
        serve(0, 1'b0);
        serve(0, 1'b0);
        wait_start();
        check("m17_type", command_type, 32'd17);
        finish = 1'b1; tick();
        repeat (100) tick();
        check("m17_no_pop", 32'(count), 32'd1);
        finish = 1'b0; tick();
        check("m17_popped", 32'(count), 32'd0);

        // Full queue, refused write, drain, then wrap-around
        for (int pass = 0; pass < 2; pass++) begin
            pause = 1'b1;
            for (int i = 0; i < 16; i++)
                wr(32'(200 + 16 * pass + i), 32'(i), 32'(-i), 32'(2 * i), 32'(3 * i), 32'(pass));
            check("full_count", 32'(count), 32'd16);
            check("full_wr_ready", 32'(wr_ready), 32'd0);
            wr(32'hBAD, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1);
            check("full_refused", 32'(count), 32'd16);
            pause = 1'b0;
            for (int i = 0; i < 16; i++) serve(0, 1'b0);
            check("drained", 32'(count), 32'd0);
        end

        // Error halts issuing until resume
        wr(32'hDEAD, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        wr(32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7);
        serve(0, 1'b1);
        check("err_count", 32'(err_count), 32'd1);
        check("err_last", last_err_type, 32'hDEAD);
        check("err_halted", 32'(halted), 32'd1);
        repeat (5) tick();
        check("halt_no_start", 32'(start), 32'd0);
        check("halt_retained", 32'(count), 32'd1);
        resume = 1'b1; tick(); resume = 1'b0;
        check("resumed", 32'(halted), 32'd0);
        serve(0, 1'b0);
        check("after_resume", 32'(count), 32'd0);

        // Flush while a command is in flight
        pause = 1'b1;
        for (int i = 0; i < 5; i++) wr(32'(300 + i), 32'(i), 32'd0, 32'd0, 32'd0, 32'd0);
        pause = 1'b0;
        wait_start();
        flush = 1'b1; #1;
        check("flush_wr_ready", 32'(wr_ready), 32'd0);
        tick(); flush = 1'b0;
        check("flush_count", 32'(count), 32'd1);
        check("flush_start_held", 32'(start), 32'd1);
        finish = 1'b1; tick(); finish = 1'b0; tick();
        check("flush_empty", 32'(count), 32'd0);
        repeat (4) tick();
        check("flush_idle", 32'(start), 32'd0);

        // Write and pop in the same cycle
        pause = 1'b1;
        wr(32'd401, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0);
        wr(32'd402, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0);
        pause = 1'b0;
        wait_start();
        finish = 1'b1; tick();
        finish = 1'b0;
        wr(32'd403, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0);
        check("wr_pop_count", 32'(count), 32'd2);
        serve(0, 1'b0);
        serve(0, 1'b0);
        check("wr_pop_drained", 32'(count), 32'd0);

        // Asynchronous reset in the middle of ISSUE
        wr(32'd500, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5);
        wait_start();
        #2 reset = 1'b1;
        #1;
        check("arst_start", 32'(start), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_err_count", 32'(err_count), 32'd0);
        tick(); reset = 1'b0;
        wr(32'd600, 32'd6, 32'd6, 32'd6, 32'd6, 32'd6);
        serve(0, 1'b0);
        check("post_reset", 32'(count), 32'd0);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
